// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl: washing-machine program controller.
//   Sequences soap check, fill, wash, drain, rinse and spin phases for five
//   programs (cold, hot, rinse+dry, dry only, quick), with pause/resume,
//   door-open fault handling and a remaining-cycles display.
// Ports:
//   clk, rst (sync, active high), power (0 = forced idle)
//   program_selection, rinse_count, start, pause, doorclosed, soap : panel/sensors
//   eco (only with WASH_ECO_EN) : halves wash/rinse, replaces hot fill by cold
//   valve_in_cold, valve_in_hot, valve_out, motor : actuator drives
//   timer_display : cycles remaining in the current phase
//   program_done, soap_warning, soap_in, lockDoor, fault : status
// Optional feature macro: WASH_ECO_EN.
module wash_cycle_ctrl #(
  parameter int unsigned TIMER_W     = 8,
  parameter int unsigned FILL_T      = 10,
  parameter int unsigned WASH_T      = 20,
  parameter int unsigned RINSE_T     = 15,
  parameter int unsigned DRAIN_T     = 8,
  parameter int unsigned SPIN_T      = 10,
  parameter int unsigned SOAP_WAIT_T = 30,
  parameter int unsigned RINSE_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power,
  input  logic [2:0]         program_selection,
  input  logic [RINSE_W-1:0] rinse_count,
  input  logic               start,
  input  logic               pause,
  input  logic               doorclosed,
  input  logic               soap,
`ifdef WASH_ECO_EN
  input  logic               eco,
`endif
  output logic               valve_in_cold,
  output logic               valve_in_hot,
  output logic               valve_out,
  output logic [1:0]         motor,
  output logic [TIMER_W-1:0] timer_display,
  output logic               program_done,
  output logic               soap_warning,
  output logic               soap_in,
  output logic               lockDoor,
  output logic               fault
);

  typedef enum logic [3:0] {
    StIdle, StSoapWait, StFill, StWash, StDrain, StRinseFill,
    StRinse, StSpin, StPaused, StDone, StFault
  } state_e;

  localparam logic [2:0] ProgCold     = 3'b000;
  localparam logic [2:0] ProgHot      = 3'b001;
  localparam logic [2:0] ProgRinseDry = 3'b010;
  localparam logic [2:0] ProgQuick    = 3'b100;

  localparam int unsigned QuickWashT = (WASH_T / 2 > 0) ? WASH_T / 2 : 1;

  localparam logic [TIMER_W-1:0] FillLen      = TIMER_W'(FILL_T);
  localparam logic [TIMER_W-1:0] WashLen      = TIMER_W'(WASH_T);
  localparam logic [TIMER_W-1:0] QuickWashLen = TIMER_W'(QuickWashT);
  localparam logic [TIMER_W-1:0] RinseLen     = TIMER_W'(RINSE_T);
  localparam logic [TIMER_W-1:0] DrainLen     = TIMER_W'(DRAIN_T);
  localparam logic [TIMER_W-1:0] SpinLen      = TIMER_W'(SPIN_T);
  localparam logic [TIMER_W-1:0] SoapLen      = TIMER_W'(SOAP_WAIT_T);
  localparam logic [TIMER_W-1:0] CntOne       = TIMER_W'(1);

  state_e               state_q, state_d, saved_q, saved_d, cur;
  logic [TIMER_W-1:0]   cnt_q, cnt_d, wash_len, rinse_len;
  logic [2:0]           prog_q, prog_d;
  logic [RINSE_W-1:0]   rinse_q, rinse_d;
  logic                 first_q, first_d;
  logic                 load, step_phase, hot_sel;

`ifdef WASH_ECO_EN
  logic eco_q, eco_d;

  function automatic logic [TIMER_W-1:0] half_min1(input logic [TIMER_W-1:0] v);
    return (v > CntOne) ? (v >> 1) : CntOne;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      saved_q <= StIdle;
      cnt_q   <= '0;
      prog_q  <= '0;
      rinse_q <= '0;
      first_q <= 1'b0;
`ifdef WASH_ECO_EN
      eco_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      prog_q  <= prog_d;
      rinse_q <= rinse_d;
      first_q <= first_d;
`ifdef WASH_ECO_EN
      eco_q   <= eco_d;
`endif
    end
  end

  // Phase lengths that depend on the latched program.
  always_comb begin
    wash_len  = (prog_q == ProgQuick) ? QuickWashLen : WashLen;
    rinse_len = RinseLen;
`ifdef WASH_ECO_EN
    if (eco_q) begin
      wash_len  = half_min1(wash_len);
      rinse_len = half_min1(rinse_len);
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    cnt_d      = cnt_q;
    prog_d     = prog_q;
    rinse_d    = rinse_q;
    first_d    = 1'b0;  // soap pulse lasts exactly one cycle
    load       = 1'b0;
    step_phase = 1'b0;
`ifdef WASH_ECO_EN
    eco_d      = eco_q;
`endif
    // A paused controller resumes by stepping the phase it was frozen in.
    cur = (state_q == StPaused) ? saved_q : state_q;

    if (!power) begin
      state_d = StIdle;
      saved_d = StIdle;
      cnt_d   = '0;
      prog_d  = '0;
      rinse_d = '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (state_q == StDone && !doorclosed) begin
            state_d = StIdle;
          end else if (start && doorclosed && program_selection <= ProgQuick) begin
            prog_d = program_selection;
            load   = 1'b1;
`ifdef WASH_ECO_EN
            eco_d  = eco;
`endif
            case (program_selection)
              ProgCold, ProgHot, ProgQuick: begin
                rinse_d = (program_selection == ProgQuick) ? '0 : rinse_count;
                if (soap) begin
                  state_d = StFill;
                  first_d = 1'b1;
                end else begin
                  state_d = StSoapWait;
                end
              end
              ProgRinseDry: begin
                if (rinse_count != '0) begin
                  state_d = StRinseFill;
                  rinse_d = rinse_count - RINSE_W'(1);
                end else begin
                  state_d = StSpin;
                  rinse_d = '0;
                end
              end
              default: begin
                state_d = StSpin;
                rinse_d = '0;
              end
            endcase
          end
        end
        StSoapWait: begin
          if (!doorclosed) begin
            state_d = StFault;
            cnt_d   = '0;
          end else if (soap) begin
            state_d = StFill;
            first_d = 1'b1;
            load    = 1'b1;
          end else if (cnt_q == CntOne) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StFill, StWash, StDrain, StRinseFill, StRinse, StSpin: begin
          if (!doorclosed) begin
            state_d = StFault;
            cnt_d   = '0;
          end else if (pause) begin
            state_d = StPaused;
            saved_d = state_q;
          end else begin
            step_phase = 1'b1;
          end
        end
        StPaused: begin
          if (!doorclosed) begin
            state_d = StFault;
            cnt_d   = '0;
          end else if (!pause) begin
            step_phase = 1'b1;
          end
        end
        StFault: begin
          if (start && doorclosed) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase

      if (step_phase) begin
        if (cnt_q != CntOne) begin
          state_d = cur;
          cnt_d   = cnt_q - CntOne;
        end else begin
          load = 1'b1;
          case (cur)
            StFill:      state_d = StWash;
            StWash:      state_d = StDrain;
            StDrain: begin
              if (rinse_q != '0) begin
                state_d = StRinseFill;
                rinse_d = rinse_q - RINSE_W'(1);
              end else begin
                state_d = StSpin;
              end
            end
            StRinseFill: state_d = StRinse;
            StRinse:     state_d = StDrain;
            default:     state_d = StDone;
          endcase
        end
      end

      if (load) begin
        case (state_d)
          StSoapWait:  cnt_d = SoapLen;
          StFill:      cnt_d = FillLen;
          StWash:      cnt_d = wash_len;
          StDrain:     cnt_d = DrainLen;
          StRinseFill: cnt_d = FillLen;
          StRinse:     cnt_d = rinse_len;
          StSpin:      cnt_d = SpinLen;
          default:     cnt_d = '0;
        endcase
      end
    end
  end

  always_comb begin
    hot_sel = (prog_q == ProgHot);
`ifdef WASH_ECO_EN
    if (eco_q) hot_sel = 1'b0;
`endif
    valve_in_cold = 1'b0;
    valve_in_hot  = 1'b0;
    valve_out     = 1'b0;
    motor         = 2'b00;
    case (state_q)
      StFill: begin
        valve_in_hot  = hot_sel;
        valve_in_cold = !hot_sel;
      end
      StRinseFill:     valve_in_cold = 1'b1;
      StWash, StRinse: motor = 2'b01;
      StDrain:         valve_out = 1'b1;
      StSpin: begin
        valve_out = 1'b1;
        motor     = 2'b10;
      end
      default: ;
    endcase
    timer_display = cnt_q;
    program_done  = (state_q == StDone);
    soap_warning  = (state_q == StSoapWait);
    soap_in       = (state_q == StFill) && first_q;
    fault         = (state_q == StFault);
    lockDoor      = !(state_q inside {StIdle, StDone, StFault});
  end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl: program table, hand-written corner
// sequences, then randomized stimulus against a phase-list reference model.
module tb_wash_cycle_ctrl;
  localparam int FILL_T = 10, WASH_T = 20, RINSE_T = 15, DRAIN_T = 8;
  localparam int SPIN_T = 10, SOAP_WAIT_T = 30;

  logic clk = 1'b0;
  logic rst, power, start, pause, doorclosed, soap;
  logic [2:0] program_selection;
  logic [1:0] rinse_count;
`ifdef WASH_ECO_EN
  logic eco = 1'b0;
`endif
  logic valve_in_cold, valve_in_hot, valve_out, program_done, soap_warning;
  logic soap_in, lockDoor, fault;
  logic [1:0] motor;
  logic [7:0] timer_display;

  always #5 clk = ~clk;

  wash_cycle_ctrl #(
    .TIMER_W(8), .FILL_T(FILL_T), .WASH_T(WASH_T), .RINSE_T(RINSE_T),
    .DRAIN_T(DRAIN_T), .SPIN_T(SPIN_T), .SOAP_WAIT_T(SOAP_WAIT_T), .RINSE_W(2)
  ) dut (
    .clk(clk), .rst(rst), .power(power), .program_selection(program_selection),
    .rinse_count(rinse_count), .start(start), .pause(pause), .doorclosed(doorclosed),
    .soap(soap),
`ifdef WASH_ECO_EN
    .eco(eco),
`endif
    .valve_in_cold(valve_in_cold), .valve_in_hot(valve_in_hot), .valve_out(valve_out),
    .motor(motor), .timer_display(timer_display), .program_done(program_done),
    .soap_warning(soap_warning), .soap_in(soap_in), .lockDoor(lockDoor), .fault(fault)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] dut_outs();
    return {valve_in_cold, valve_in_hot, valve_out, motor, timer_display,
            program_done, soap_warning, soap_in, lockDoor, fault};
  endfunction

  task automatic do_reset();
    rst = 1'b1; power = 1'b1; start = 1'b0; pause = 1'b0; doorclosed = 1'b1;
    soap = 1'b1; program_selection = 3'd0; rinse_count = 2'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Counts activity from the current cycle until program_done (-1 on timeout).
  task automatic measure(output int total, output int hot, output int cold,
                         output int agit, output int spin, output int sin);
    total = 0; hot = 0; cold = 0; agit = 0; spin = 0; sin = 0;
    for (int i = 0; i < 400 && !program_done; i++) begin
      total++;
      hot  += int'(valve_in_hot);
      cold += int'(valve_in_cold);
      agit += int'(motor == 2'b01);
      spin += int'(motor == 2'b10);
      sin  += int'(soap_in);
      step();
    end
    if (!program_done) total = -1;
  endtask

  task automatic launch(input logic [2:0] p, input logic [1:0] rc, input logic s);
    program_selection = p; rinse_count = rc; soap = s; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ---------------- reference model: program as a list of phases ----------
  localparam int KFill = 0, KWash = 1, KDrain = 2, KRfill = 3, KRinse = 4, KSpin = 5;
  localparam int MIdle = 0, MSoap = 1, MRun = 2, MPause = 3, MDone = 4, MFault = 5;
  int m_kind[$];
  int m_len[$];
  int m_mode, m_idx, m_rem;
  logic [2:0] m_prog;
  bit m_first;

  task automatic build(input logic [2:0] p, input logic [1:0] rc);
    m_kind.delete();
    m_len.delete();
    if (p == 3'd0 || p == 3'd1 || p == 3'd4) begin
      m_kind.push_back(KFill);  m_len.push_back(FILL_T);
      m_kind.push_back(KWash);  m_len.push_back(p == 3'd4 ? WASH_T / 2 : WASH_T);
      m_kind.push_back(KDrain); m_len.push_back(DRAIN_T);
    end
    if (p == 3'd0 || p == 3'd1 || p == 3'd2) begin
      for (int i = 0; i < int'(rc); i++) begin
        m_kind.push_back(KRfill); m_len.push_back(FILL_T);
        m_kind.push_back(KRinse); m_len.push_back(RINSE_T);
        m_kind.push_back(KDrain); m_len.push_back(DRAIN_T);
      end
    end
    m_kind.push_back(KSpin); m_len.push_back(SPIN_T);
  endtask

  task automatic m_advance();
    if (m_rem == 1) begin
      m_idx++;
      if (m_idx >= m_kind.size()) begin
        m_mode = MDone;
        m_rem = 0;
      end else begin
        m_mode = MRun;
        m_rem = m_len[m_idx];
      end
    end else begin
      m_mode = MRun;
      m_rem--;
    end
  endtask

  task automatic model_step();
    bit wash_prog;
    wash_prog = (program_selection == 3'd0 || program_selection == 3'd1 ||
                 program_selection == 3'd4);
    m_first = 1'b0;
    if (rst || !power) begin
      m_mode = MIdle; m_rem = 0;
    end else begin
      case (m_mode)
        MIdle, MDone: begin
          if (m_mode == MDone && !doorclosed) m_mode = MIdle;
          else if (start && doorclosed && program_selection <= 3'd4) begin
            build(program_selection, rinse_count);
            m_prog = program_selection;
            m_idx = 0;
            if (wash_prog && !soap) begin
              m_mode = MSoap; m_rem = SOAP_WAIT_T;
            end else begin
              m_mode = MRun; m_rem = m_len[0]; m_first = wash_prog;
            end
          end
        end
        MSoap: begin
          if (!doorclosed) begin m_mode = MFault; m_rem = 0; end
          else if (soap) begin m_mode = MRun; m_rem = m_len[0]; m_first = 1'b1; end
          else if (m_rem == 1) begin m_mode = MIdle; m_rem = 0; end
          else m_rem--;
        end
        MRun: begin
          if (!doorclosed) begin m_mode = MFault; m_rem = 0; end
          else if (pause) m_mode = MPause;
          else m_advance();
        end
        MPause: begin
          if (!doorclosed) begin m_mode = MFault; m_rem = 0; end
          else if (!pause) m_advance();
        end
        default: if (start && doorclosed) m_mode = MIdle;
      endcase
    end
  endtask

  function automatic logic [17:0] exp_outs();
    logic c, h, vo;
    logic [1:0] mo;
    c = 1'b0; h = 1'b0; vo = 1'b0; mo = 2'b00;
    if (m_mode == MRun) begin
      case (m_kind[m_idx])
        KFill:  begin h = (m_prog == 3'd1); c = (m_prog != 3'd1); end
        KRfill: c = 1'b1;
        KWash, KRinse: mo = 2'b01;
        KDrain: vo = 1'b1;
        default: begin vo = 1'b1; mo = 2'b10; end
      endcase
    end
    return {c, h, vo, mo, 8'(m_rem), m_mode == MDone, m_mode == MSoap,
            (m_mode == MRun) && m_first,
            (m_mode == MSoap || m_mode == MRun || m_mode == MPause), m_mode == MFault};
  endfunction

  // ---------------- program table ----------------
  typedef struct {
    logic [2:0] prog;
    logic [1:0] rc;
    int total, hot, cold, agit, spin, sin;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int total, hot, cold, agit, spin, sin, w, act, pre;

    tbl[0] = '{3'd0, 2'd1, 81, 0, 20, 35, 10, 1};
    tbl[1] = '{3'd1, 2'd1, 81, 10, 10, 35, 10, 1};
    tbl[2] = '{3'd2, 2'd2, 76, 0, 20, 30, 10, 0};
    tbl[3] = '{3'd2, 2'd0, 10, 0, 0, 0, 10, 0};
    tbl[4] = '{3'd3, 2'd3, 10, 0, 0, 0, 10, 0};
    tbl[5] = '{3'd4, 2'd3, 38, 0, 10, 10, 10, 1};
    tbl[6] = '{3'd1, 2'd0, 48, 10, 0, 20, 10, 1};
    tbl[7] = '{3'd0, 2'd3, 147, 0, 40, 65, 10, 1};

    do_reset();
    chk("reset_outputs", int'(dut_outs()), 0);

    // Cold, rinse 1: first FILL cycle details.
    launch(3'd0, 2'd1, 1'b1);
    chk("cold_fill_valve", int'(valve_in_cold), 1);
    chk("cold_soap_pulse", int'(soap_in), 1);
    chk("cold_timer_first", int'(timer_display), 10);
    step();
    chk("cold_soap_pulse_off", int'(soap_in), 0);
    chk("cold_timer_second", int'(timer_display), 9);

    foreach (tbl[i]) begin
      do_reset();
      launch(tbl[i].prog, tbl[i].rc, 1'b1);
      measure(total, hot, cold, agit, spin, sin);
      chk($sformatf("tbl%0d_total", i), total, tbl[i].total);
      chk($sformatf("tbl%0d_hot", i), hot, tbl[i].hot);
      chk($sformatf("tbl%0d_cold", i), cold, tbl[i].cold);
      chk($sformatf("tbl%0d_agit", i), agit, tbl[i].agit);
      chk($sformatf("tbl%0d_spin", i), spin, tbl[i].spin);
      chk($sformatf("tbl%0d_soapin", i), sin, tbl[i].sin);
      chk($sformatf("tbl%0d_done_unlock", i), int'(lockDoor), 0);
      chk($sformatf("tbl%0d_done_timer", i), int'(timer_display), 0);
    end

    // Hot, soap arrives after 5 waiting cycles.
    do_reset();
    launch(3'd1, 2'd1, 1'b0);
    w = 0;
    repeat (4) begin w += int'(soap_warning); step(); end
    w += int'(soap_warning);
    soap = 1'b1;
    step();
    chk("soapwait_cycles", w, 5);
    chk("soapwait_cleared", int'(soap_warning), 0);
    chk("soapwait_hot_fill", int'(valve_in_hot), 1);
    measure(total, hot, cold, agit, spin, sin);
    chk("soapwait_hot_cycles", hot, 10);
    chk("soapwait_rinse_cold", cold, 10);
    chk("soapwait_total", total, 81);

    // Soap never present: abort to IDLE after the timeout.
    do_reset();
    launch(3'd0, 2'd1, 1'b0);
    w = 0; act = 0;
    repeat (30) begin
      w += int'(soap_warning);
      act += int'(valve_in_cold | valve_in_hot | valve_out | (motor != 2'b00));
      step();
    end
    chk("soapto_warn_cycles", w, 30);
    chk("soapto_no_activity", act, 0);
    chk("soapto_idle_unlock", int'(lockDoor), 0);
    chk("soapto_not_done", int'(program_done), 0);
    chk("soapto_warn_off", int'(soap_warning), 0);

    // Quick wash paused for 7 cycles at WASH timer 6.
    do_reset();
    launch(3'd4, 2'd0, 1'b1);
    pre = 1;
    for (int i = 0; i < 100 && !(motor == 2'b01 && timer_display == 8'd6); i++) begin
      pre++;
      step();
    end
    chk("pause_reached_wash6", int'(motor == 2'b01 && timer_display == 8'd6), 1);
    pause = 1'b1;
    step();
    chk("pause_outputs_off", int'({valve_in_cold, valve_in_hot, valve_out, motor}), 0);
    chk("pause_timer_hold", int'(timer_display), 6);
    chk("pause_locked", int'(lockDoor), 1);
    repeat (6) begin pre++; step(); end
    pre++;
    pause = 1'b0;
    step();
    chk("resume_motor", int'(motor), 1);
    chk("resume_timer", int'(timer_display), 5);
    measure(total, hot, cold, agit, spin, sin);
    chk("pause_total", (total < 0) ? -1 : pre + total, 45);

    // Door opened during SPIN.
    do_reset();
    launch(3'd3, 2'd0, 1'b1);
    step();
    step();
    doorclosed = 1'b0;
    step();
    chk("door_fault", int'(fault), 1);
    chk("door_motor_off", int'(motor), 0);
    chk("door_unlock", int'(lockDoor), 0);
    doorclosed = 1'b1;
    step();
    chk("door_fault_held", int'(fault), 1);
    launch(3'd3, 2'd0, 1'b1);
    chk("door_clear_fault", int'(fault), 0);
    step();
    chk("door_no_launch", int'(lockDoor), 0);

    // Synchronous reset in the middle of FILL.
    do_reset();
    launch(3'd0, 2'd1, 1'b1);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("rst_midfill", int'(dut_outs()), 0);
    rst = 1'b0;

    // Power loss during a run.
    launch(3'd4, 2'd0, 1'b1);
    repeat (15) step();
    power = 1'b0;
    step();
    chk("power_off", int'(dut_outs()), 0);
    power = 1'b1;
    step();
    chk("power_stays_idle", int'(lockDoor), 0);

    // Ignored starts.
    launch(3'd5, 2'd0, 1'b1);
    chk("invalid_code_ignored", int'(lockDoor), 0);
    doorclosed = 1'b0;
    launch(3'd0, 2'd0, 1'b1);
    chk("door_open_start_ignored", int'(lockDoor), 0);
    doorclosed = 1'b1;

    // Randomized run against the model.
    rst = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 1999) == 0);
      power = ($urandom_range(0, 499) != 0);
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      doorclosed = ($urandom_range(0, 299) != 0);
      soap = ($urandom_range(0, 3) != 0);
      program_selection = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4))
                                                     : 3'($urandom_range(0, 7));
      rinse_count = 2'($urandom_range(0, 3));
      @(posedge clk);
      model_step();
      #1;
      checks++;
      if (dut_outs() !== exp_outs()) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %b expected %b", c, dut_outs(), exp_outs());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
